enc_dec_serial_core: RTL

- Parametrised, synthesizable successor to the fixed-width encoder/decoder golden model.
- APB-slave register file plus serial extended-Hamming (SECDED) engine for 8/16/32-bit codewords.
- Three modes: encode, decode, and full channel (encode, XOR NOISE, decode).
- Syndrome is computed one codeword bit per cycle, so latency scales with width; adds BUSY/STATUS readback not present in the golden model.

---
 rtl/enc_dec_serial_core.sv | 302 ++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/enc_dec_serial_core.sv
// enc_dec_serial_core: APB register file around a bit-serial extended-Hamming
// (SECDED) engine for 8/16/32-bit codewords. Modes: encode, decode, and full
// channel (encode, inject NOISE, decode). The syndrome is accumulated one
// codeword bit per clock.
module enc_dec_serial_core #(
    parameter int AMBA_WORD       = 32,
    parameter int AMBA_ADDR_WIDTH = 20,
    parameter int MAX_CW          = 32
) (
    input  logic                       PCLK,
    input  logic                       PRESETn,
    input  logic                       PSEL,
    input  logic                       PENABLE,
    input  logic                       PWRITE,
    input  logic [AMBA_ADDR_WIDTH-1:0] PADDR,
    input  logic [AMBA_WORD-1:0]       PWDATA,
    output logic [AMBA_WORD-1:0]       PRDATA,
    output logic                       PREADY,
    output logic [AMBA_WORD-1:0]       data_out,
    output logic                       operation_done,
    output logic [1:0]                 num_of_errors,
    output logic                       busy
);

    localparam int CW_BITS = $clog2(MAX_CW);
    localparam int AW_BITS = $clog2(AMBA_WORD);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_LOAD    = 3'd1;
    localparam logic [2:0] S_SCAN    = 3'd2;
    localparam logic [2:0] S_FIX_ENC = 3'd3;
    localparam logic [2:0] S_FIX_DEC = 3'd4;
    localparam logic [2:0] S_DONE    = 3'd5;

    localparam logic [1:0] MODE_ENC  = 2'b00;
    localparam logic [1:0] MODE_DEC  = 2'b01;
    localparam logic [1:0] MODE_FULL = 2'b10;

    localparam logic [2:0] REG_CTRL   = 3'd0;
    localparam logic [2:0] REG_DATA   = 3'd1;
    localparam logic [2:0] REG_WIDTH  = 3'd2;
    localparam logic [2:0] REG_NOISE  = 3'd3;
    localparam logic [2:0] REG_STATUS = 3'd4;

    // Register file
    logic [1:0]           ctrl_reg;
    logic [AMBA_WORD-1:0] data_in_reg;
    logic [1:0]           width_reg;
    logic [AMBA_WORD-1:0] noise_reg;
    logic                 wr_dropped;

    // Engine state
    logic [2:0]           state;
    logic [CW_BITS-1:0]   cnt;
    logic [CW_BITS-1:0]   syn;
    logic                 par;
    logic [MAX_CW-1:0]    work;
    logic                 enc_pass_done;

    logic                 wr_en;
    logic                 rd_setup;
    logic [2:0]           reg_sel;
    logic                 start;
    logic [CW_BITS:0]     cw_w;
    logic [CW_BITS-1:0]   last_idx;
    logic [MAX_CW-1:0]    cw_mask;
    logic [MAX_CW-1:0]    enc_word;
    logic [MAX_CW-1:0]    flip_vec;
    logic [MAX_CW-1:0]    fixed_word;
    logic                 unused_paddr;

    // Position p (p > 0) is a Hamming parity position when it is a power of two.
    function automatic logic is_pow2(input int p);
        return (p & (p - 1)) == 0;
    endfunction

    // Codeword width selected by the CODEWORD_WIDTH register.
    function automatic logic [CW_BITS:0] width_of(input logic [1:0] sel);
        case (sel)
            2'd0:    return (CW_BITS+1)'(8);
            2'd1:    return (CW_BITS+1)'(16);
            default: return (CW_BITS+1)'(MAX_CW);
        endcase
    endfunction

    // Ones in the low w bits.
    function automatic logic [MAX_CW-1:0] width_mask(input logic [CW_BITS:0] w);
        logic [MAX_CW-1:0] m;
        m = '0;
        for (int p = 0; p < MAX_CW; p++) begin
            m[p[CW_BITS-1:0]] = (p < int'(w));
        end
        return m;
    endfunction

    // Scatter data bits LSB-first into non-parity positions 3,5,6,7,9,...
    function automatic logic [MAX_CW-1:0] place_data(input logic [AMBA_WORD-1:0] d,
                                                     input logic [CW_BITS:0]   w);
        logic [MAX_CW-1:0] cw;
        int k;
        cw = '0;
        k  = 0;
        for (int p = 1; p < MAX_CW; p++) begin
            if (p < int'(w) && !is_pow2(p)) begin
                cw[p[CW_BITS-1:0]] = d[k[AW_BITS-1:0]];
                k++;
            end
        end
        return cw;
    endfunction

    // Gather the data bits back out of the non-parity positions.
    function automatic logic [MAX_CW-1:0] extract_data(input logic [MAX_CW-1:0] cw,
                                                       input logic [CW_BITS:0]  w);
        logic [MAX_CW-1:0] d;
        int k;
        d = '0;
        k = 0;
        for (int p = 1; p < MAX_CW; p++) begin
            if (p < int'(w) && !is_pow2(p)) begin
                d[k[CW_BITS-1:0]] = cw[p[CW_BITS-1:0]];
                k++;
            end
        end
        return d;
    endfunction

    // Drop the syndrome into the parity positions; bit 0 makes overall parity
    // even, accounting for the data ones (par) and the parity ones just added.
    function automatic logic [MAX_CW-1:0] set_parity(input logic [MAX_CW-1:0]  cw,
                                                     input logic [CW_BITS-1:0] s,
                                                     input logic               pa,
                                                     input logic [CW_BITS:0]   w);
        logic [MAX_CW-1:0] o;
        int pos;
        o = cw;
        for (int k = 0; k < CW_BITS; k++) begin
            pos = 1 << k;
            if (pos < int'(w)) begin
                o[pos[CW_BITS-1:0]] = s[k];
            end
        end
        o[0] = pa ^ (^s);
        return o;
    endfunction

    assign PREADY       = 1'b1;
    assign wr_en        = PSEL & PENABLE & PWRITE;
    assign rd_setup     = PSEL & ~PENABLE & ~PWRITE;
    assign reg_sel      = PADDR[4:2];
    assign start        = wr_en & ~busy & (reg_sel == REG_CTRL) & (PWDATA[1:0] != 2'b11);
    assign cw_w         = width_of(width_reg);
    assign last_idx     = CW_BITS'(cw_w - 1'b1);
    assign cw_mask      = width_mask(cw_w);
    assign enc_word     = set_parity(work, syn, par, cw_w);
    assign unused_paddr = ^{PADDR[AMBA_ADDR_WIDTH-1:5], PADDR[1:0]};

    // Single-error correction mask: par=1 means an odd number of flips, and the
    // syndrome names the flipped position (0 means the overall parity bit).
    always_comb begin
        flip_vec      = '0;
        flip_vec[syn] = par;
        fixed_word    = work ^ flip_vec;
    end

    // APB register writes, write-drop flag and registered read data.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            ctrl_reg    <= '0;
            data_in_reg <= '0;
            width_reg   <= '0;
            noise_reg   <= '0;
            wr_dropped  <= 1'b0;
            PRDATA      <= '0;
        end else begin
            if (wr_en) begin
                if (busy) begin
                    wr_dropped <= 1'b1;
                end else begin
                    case (reg_sel)
                        REG_CTRL:  ctrl_reg    <= PWDATA[1:0];
                        REG_DATA:  data_in_reg <= PWDATA;
                        REG_WIDTH: width_reg   <= PWDATA[1:0];
                        REG_NOISE: noise_reg   <= PWDATA;
                        default:   ;
                    endcase
                end
            end
            if (rd_setup) begin
                case (reg_sel)
                    REG_CTRL:   PRDATA <= {{(AMBA_WORD-2){1'b0}}, ctrl_reg};
                    REG_DATA:   PRDATA <= data_in_reg;
                    REG_WIDTH:  PRDATA <= {{(AMBA_WORD-2){1'b0}}, width_reg};
                    REG_NOISE:  PRDATA <= noise_reg;
                    REG_STATUS: begin
                        PRDATA     <= {{(AMBA_WORD-4){1'b0}}, busy, num_of_errors, wr_dropped};
                        wr_dropped <= 1'b0;
                    end
                    default:    PRDATA <= '0;
                endcase
            end
        end
    end

    // Serial SECDED engine: load, bit-serial syndrome scan, parity insertion or
    // correction, and the one-cycle completion pulse.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state          <= S_IDLE;
            cnt            <= '0;
            syn            <= '0;
            par            <= 1'b0;
            work           <= '0;
            enc_pass_done  <= 1'b0;
            busy           <= 1'b0;
            operation_done <= 1'b0;
            num_of_errors  <= 2'd0;
            data_out       <= '0;
        end else begin
            operation_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state <= S_LOAD;
                        busy  <= 1'b1;
                    end
                end
                S_LOAD: begin
                    if (ctrl_reg == MODE_DEC) begin
                        work <= data_in_reg[MAX_CW-1:0] & cw_mask;
                    end else begin
                        work <= place_data(data_in_reg, cw_w);
                    end
                    syn           <= '0;
                    par           <= 1'b0;
                    cnt           <= '0;
                    enc_pass_done <= 1'b0;
                    state         <= S_SCAN;
                end
                S_SCAN: begin
                    if (work[cnt]) begin
                        par <= ~par;
                        syn <= syn ^ cnt;
                    end
                    if (cnt == last_idx) begin
                        cnt <= '0;
                        if (ctrl_reg == MODE_ENC || (ctrl_reg == MODE_FULL && !enc_pass_done)) begin
                            state <= S_FIX_ENC;
                        end else begin
                            state <= S_FIX_DEC;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_FIX_ENC: begin
                    if (ctrl_reg == MODE_ENC) begin
                        data_out       <= AMBA_WORD'(enc_word);
                        num_of_errors  <= 2'd0;
                        operation_done <= 1'b1;
                        busy           <= 1'b0;
                        state          <= S_DONE;
                    end else begin
                        work          <= enc_word ^ (noise_reg[MAX_CW-1:0] & cw_mask);
                        syn           <= '0;
                        par           <= 1'b0;
                        enc_pass_done <= 1'b1;
                        state         <= S_SCAN;
                    end
                end
                S_FIX_DEC: begin
                    if (par) begin
                        num_of_errors <= 2'd1;
                        data_out      <= AMBA_WORD'(extract_data(fixed_word, cw_w));
                    end else if (syn != '0) begin
                        num_of_errors <= 2'd2;
                        data_out      <= '0;
                    end else begin
                        num_of_errors <= 2'd0;
                        data_out      <= AMBA_WORD'(extract_data(work, cw_w));
                    end
                    operation_done <= 1'b1;
                    busy           <= 1'b0;
                    state          <= S_DONE;
                end
                S_DONE: begin
                    if (start) begin
                        state <= S_LOAD;
                        busy  <= 1'b1;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
